key_mode_ctrl: RTL

Key-driven mode controller for the LCD1602 alarm clock. Consumes the one-cycle key pulses produced by the per-key debouncers and sequences the clock-set and alarm-set fields through an edit state machine. It owns the alarm time and alarm enable registers, issues a one-cycle load strobe to the timekeeping counter, and drives the field/blink information used by the LCD writer.

---
 rtl/key_mode_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - key-driven clock/alarm edit mode controller
//
// Sequences the clock-set and alarm-set fields from debounced one-cycle key
// pulses, owns the alarm time and alarm enable registers, and strobes a new
// time into the timekeeping counter when the clock fields are committed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_mode              advance IDLE->SET_HOUR->SET_MIN->ALM_HOUR->ALM_MIN->IDLE
//   key_up, key_down      step the active field (+1 / -1, wrapping)
//   key_alm               toggle alarm_en (IDLE only)
//   cur_hour, cur_min     running clock time, captured on entry to SET_HOUR
//   mode                  0 IDLE, 1 SET_HOUR, 2 SET_MIN, 3 ALM_HOUR, 4 ALM_MIN
//   edit_hour, edit_min   value being edited
//   blink                 field blink phase, 1 = show field
//   time_load             one-cycle strobe with time_hour/time_min
//   alarm_hour, alarm_min stored alarm time
//   alarm_en              alarm armed

module key_mode_ctrl #(
  parameter int unsigned TIMEOUT   = 500_000_000,
  parameter int unsigned BLINK_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_alm,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [2:0] mode,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic       blink,
  output logic       time_load,
  output logic [4:0] time_hour,
  output logic [5:0] time_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_en
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BL_W = $clog2(BLINK_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_HOUR = 3'd1,
    S_SET_MIN  = 3'd2,
    S_ALM_HOUR = 3'd3,
    S_ALM_MIN  = 3'd4
  } mode_e;

  mode_e state_q, state_d;

  logic [4:0]      edit_hour_q, edit_hour_d;
  logic [5:0]      edit_min_q, edit_min_d;
  logic            blink_q, blink_d;
  logic            time_load_q, time_load_d;
  logic [4:0]      time_hour_q, time_hour_d;
  logic [5:0]      time_min_q, time_min_d;
  logic [4:0]      alarm_hour_q, alarm_hour_d;
  logic [5:0]      alarm_min_q, alarm_min_d;
  logic            alarm_en_q, alarm_en_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;

  logic any_key;
  logic in_edit;
  logic step_up;
  logic step_dn;
  logic timed_out;

  // key_mode beats up/down; up together with down cancels out.
  assign any_key   = key_mode | key_up | key_down | key_alm;
  assign in_edit   = (state_q != S_IDLE);
  assign step_up   = !key_mode && key_up && !key_down;
  assign step_dn   = !key_mode && key_down && !key_up;
  assign timed_out = in_edit && !any_key && (to_cnt_q == TO_LAST);

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hour_dec(input logic [4:0] h);
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] m);
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        S_IDLE:     state_d = S_SET_HOUR;
        S_SET_HOUR: state_d = S_SET_MIN;
        S_SET_MIN:  state_d = S_ALM_HOUR;
        S_ALM_HOUR: state_d = S_ALM_MIN;
        default:    state_d = S_IDLE;
      endcase
    end else if (timed_out) begin
      state_d = S_IDLE;
    end
  end

  // Output logic: next values of every registered output and counter
  always_comb begin
    edit_hour_d  = edit_hour_q;
    edit_min_d   = edit_min_q;
    time_load_d  = 1'b0;
    time_hour_d  = time_hour_q;
    time_min_d   = time_min_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    blink_d      = blink_q;
    to_cnt_d     = to_cnt_q;
    bl_cnt_d     = bl_cnt_q;

    if (key_mode) begin
      case (state_q)
        S_IDLE: begin
          edit_hour_d = cur_hour;
          edit_min_d  = cur_min;
        end
        S_SET_MIN: begin
          // Commit the clock edit, then reuse the edit regs for the alarm.
          time_load_d = 1'b1;
          time_hour_d = edit_hour_q;
          time_min_d  = edit_min_q;
          edit_hour_d = alarm_hour_q;
          edit_min_d  = alarm_min_q;
        end
        S_ALM_MIN: begin
          alarm_hour_d = edit_hour_q;
          alarm_min_d  = edit_min_q;
        end
        default: ;
      endcase
    end else if (step_up || step_dn) begin
      case (state_q)
        S_SET_HOUR, S_ALM_HOUR:
          edit_hour_d = step_up ? hour_inc(edit_hour_q) : hour_dec(edit_hour_q);
        S_SET_MIN, S_ALM_MIN:
          edit_min_d = step_up ? min_inc(edit_min_q) : min_dec(edit_min_q);
        default: ;
      endcase
    end

    if (!in_edit && key_alm) alarm_en_d = ~alarm_en_q;

    if (!in_edit || any_key || (state_d != state_q)) to_cnt_d = '0;
    else                                             to_cnt_d = to_cnt_q + 1'b1;

    // Field stays visible in IDLE, on entering an edit state and while stepping.
    if ((state_d == S_IDLE) || (state_d != state_q) ||
        (in_edit && (key_up || key_down))) begin
      blink_d  = 1'b1;
      bl_cnt_d = '0;
    end else if (bl_cnt_q == BL_LAST) begin
      blink_d  = ~blink_q;
      bl_cnt_d = '0;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_hour_q  <= '0;
      edit_min_q   <= '0;
      blink_q      <= 1'b0;
      time_load_q  <= 1'b0;
      time_hour_q  <= '0;
      time_min_q   <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_en_q   <= 1'b0;
      to_cnt_q     <= '0;
      bl_cnt_q     <= '0;
    end else begin
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      blink_q      <= blink_d;
      time_load_q  <= time_load_d;
      time_hour_q  <= time_hour_d;
      time_min_q   <= time_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      to_cnt_q     <= to_cnt_d;
      bl_cnt_q     <= bl_cnt_d;
    end
  end

  assign mode       = state_q;
  assign edit_hour  = edit_hour_q;
  assign edit_min   = edit_min_q;
  assign blink      = blink_q;
  assign time_load  = time_load_q;
  assign time_hour  = time_hour_q;
  assign time_min   = time_min_q;
  assign alarm_hour = alarm_hour_q;
  assign alarm_min  = alarm_min_q;
  assign alarm_en   = alarm_en_q;

endmodule
